// File: rtl/mini16_trace_buffer_pkg.sv
// rtl/mini16_trace_buffer_pkg.sv - shared types and helpers for the mini16 write-event tracer
// Purpose: capture-state encoding, entry field widths and index-width helpers.
// Ports:   none (package).
package mini16_trace_buffer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Channel id field is fixed at 4 bits so up to 16 channels fit in an entry.
  localparam int CH_W = 4;

  // Entry layout, MSB to LSB: {timestamp, channel, addr, data}.
  function automatic int entry_width(input int ts_w, input int a_w, input int d_w);
    return ts_w + CH_W + a_w + d_w;
  endfunction

  // Index width that stays legal for a single-element vector.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mini16_trace_buffer_arb.sv
// rtl/mini16_trace_buffer_arb.sv - round-robin arbiter choosing one pending trace slot per cycle
// Purpose: picks the first requester at or after the rotating pointer; the pointer
//          moves one past the winner whenever the grant is consumed.
// Ports:   clk, reset_n (async, active-low), clear (pointer back to 0),
//          en (grant consumed this cycle), req (per-slot request),
//          grant (one-hot), idx (winner index), any (some request present).
module mini16_trace_buffer_arb
  import mini16_trace_buffer_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_width(N)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clear,
  input  logic          en,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW-1:0] ptr;
  int            j;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!any && req[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = IW'(j);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= '0;
    end else if (clear) begin
      ptr <= '0;
    end else if (en && any) begin
      ptr <= (int'(idx) == N - 1) ? '0 : idx + IW'(1);
    end
  end

endmodule

// File: rtl/mini16_trace_buffer.sv
// rtl/mini16_trace_buffer.sv - multi-channel write-event tracer with arm/trigger/post-trigger capture
// Purpose: snoops CHANNELS write ports, stores {ts, ch, addr, data} entries in a
//          circular RAM, freezes after the post-trigger window for readout.
// Ports:   clk, reset_n (async, active-low); ch_we/ch_addr/ch_data (packed per channel);
//          arm, trig_ext, trig_en, trig_addr, post_count (capture control);
//          rd_addr -> rd_data/rd_valid (registered readout, index 0 = oldest);
//          state, count, dropped (status).
module mini16_trace_buffer
  import mini16_trace_buffer_pkg::*;
#(
  parameter int CHANNELS  = 4,
  parameter int WIDTH_D   = 32,
  parameter int WIDTH_A   = 10,
  parameter int DEPTH_BUF = 6,
  parameter int WIDTH_TS  = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [CHANNELS-1:0]           ch_we,
  input  logic [CHANNELS*WIDTH_A-1:0]   ch_addr,
  input  logic [CHANNELS*WIDTH_D-1:0]   ch_data,
  input  logic                          arm,
  input  logic                          trig_ext,
  input  logic                          trig_en,
  input  logic [WIDTH_A-1:0]            trig_addr,
  input  logic [DEPTH_BUF-1:0]          post_count,
  input  logic [DEPTH_BUF-1:0]          rd_addr,
  output logic [WIDTH_TS+CH_W+WIDTH_A+WIDTH_D-1:0] rd_data,
  output logic                          rd_valid,
  output logic [1:0]                    state,
  output logic [DEPTH_BUF:0]            count,
  output logic [15:0]                   dropped
);

  localparam int EW = entry_width(WIDTH_TS, WIDTH_A, WIDTH_D);
  localparam int NB = 1 << DEPTH_BUF;
  localparam int IW = idx_width(CHANNELS);

  state_t                state_q, state_d;
  logic [WIDTH_TS-1:0]   ts;
  logic [CHANNELS-1:0]   full, grant, match;
  logic [EW-1:0]         slot [CHANNELS];
  logic [IW-1:0]         gidx;
  logic                  gany;
  logic [DEPTH_BUF-1:0]  wptr, post_left, phys;
  logic [EW-1:0]         ram [NB];
  logic                  capture, wr_en, trig, is_done;
  logic [4:0]            drop_n;
  logic [16:0]           drop_sum;

  mini16_trace_buffer_arb #(.N(CHANNELS), .IW(IW)) u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (arm),
    .en      (wr_en),
    .req     (full),
    .grant   (grant),
    .idx     (gidx),
    .any     (gany)
  );

  always_comb begin
    match = '0;
    for (int i = 0; i < CHANNELS; i++)
      match[i] = ch_we[i] && (ch_addr[i*WIDTH_A +: WIDTH_A] == trig_addr);
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // FSM next state; arm overrides any trigger in the same cycle
  always_comb begin
    state_d = state_q;
    if (arm) begin
      state_d = ST_ARMED;
    end else begin
      case (state_q)
        ST_ARMED: if (trig) state_d = (post_count == '0) ? ST_DONE : ST_POST;
        ST_POST:  if (wr_en && post_left == DEPTH_BUF'(1)) state_d = ST_DONE;
        default:  state_d = state_q;
      endcase
    end
  end

  // FSM outputs
  always_comb begin
    capture = (state_q == ST_ARMED || state_q == ST_POST) && !arm;
    is_done = (state_q == ST_DONE);
    trig    = (state_q == ST_ARMED) && !arm && (trig_ext || (trig_en && |match));
    wr_en   = capture && gany;
  end

  // A strobe is lost only if its slot stays occupied past this cycle.
  always_comb begin
    drop_n = '0;
    for (int i = 0; i < CHANNELS; i++)
      if (capture && ch_we[i] && full[i] && !grant[i]) drop_n = drop_n + 5'd1;
    drop_sum = {1'b0, dropped} + 17'(drop_n);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      full <= '0;
      for (int i = 0; i < CHANNELS; i++) slot[i] <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (!capture) begin
          full[i] <= 1'b0;
        end else if (ch_we[i] && (!full[i] || grant[i])) begin
          full[i] <= 1'b1;
          slot[i] <= {ts, CH_W'(i), ch_addr[i*WIDTH_A +: WIDTH_A], ch_data[i*WIDTH_D +: WIDTH_D]};
        end else if (grant[i]) begin
          full[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ts        <= '0;
      wptr      <= '0;
      count     <= '0;
      dropped   <= '0;
      post_left <= '0;
    end else begin
      ts <= ts + 1'b1;
      if (arm) begin
        wptr    <= '0;
        count   <= '0;
        dropped <= '0;
      end else begin
        if (wr_en) begin
          wptr <= wptr + 1'b1;
          if (count != (DEPTH_BUF+1)'(NB)) count <= count + 1'b1;
        end
        dropped <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      end
      if (trig)                             post_left <= post_count;
      else if (state_q == ST_POST && wr_en) post_left <= post_left - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) ram[wptr] <= slot[gidx];
  end

  // Once the buffer has wrapped, the oldest entry sits at the write pointer.
  assign phys = ((count == (DEPTH_BUF+1)'(NB)) ? wptr : '0) + rd_addr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= is_done;
      rd_data  <= is_done ? ram[phys] : '0;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_mini16_trace_buffer.sv
// tb/tb_mini16_trace_buffer.sv - scoreboard bench for mini16_trace_buffer with a queue-based reference model
module tb_mini16_trace_buffer;

  localparam int C  = 4;
  localparam int WD = 32;
  localparam int WA = 10;
  localparam int DB = 6;
  localparam int WT = 16;
  localparam int EW = WT + 4 + WA + WD;
  localparam int NB = 1 << DB;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [C-1:0]    ch_we = '0;
  logic [C*WA-1:0] ch_addr = '0;
  logic [C*WD-1:0] ch_data = '0;
  logic            arm = 1'b0;
  logic            trig_ext = 1'b0;
  logic            trig_en = 1'b0;
  logic [WA-1:0]   trig_addr = '0;
  logic [DB-1:0]   post_count = '0;
  logic [DB-1:0]   rd_addr = '0;
  logic [EW-1:0]   rd_data;
  logic            rd_valid;
  logic [1:0]      state;
  logic [DB:0]     count;
  logic [15:0]     dropped;

  always #5 clk = ~clk;

  mini16_trace_buffer dut (
    .clk(clk), .reset_n(reset_n), .ch_we(ch_we), .ch_addr(ch_addr), .ch_data(ch_data),
    .arm(arm), .trig_ext(trig_ext), .trig_en(trig_en), .trig_addr(trig_addr),
    .post_count(post_count), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .state(state), .count(count), .dropped(dropped)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: trace history is a plain queue holding the most recent NB writes.
  int            m_state;
  int            m_ts;
  int            m_drop;
  int            m_rr;
  int            m_left;
  bit            m_rdv;
  bit            m_full [C];
  logic [EW-1:0] m_pend [C];
  logic [EW-1:0] hist [$];

  function automatic int m_count();
    return (hist.size() > NB) ? NB : hist.size();
  endfunction

  task automatic model_reset();
    m_state = 0; m_ts = 0; m_drop = 0; m_rr = 0; m_left = 0; m_rdv = 0;
    hist.delete();
    for (int i = 0; i < C; i++) m_full[i] = 0;
  endtask

  task automatic model_step();
    bit matched, trg;
    int g, j;
    m_rdv = (m_state == 3);
    if (arm) begin
      m_state = 1; m_drop = 0; m_rr = 0;
      hist.delete();
      for (int i = 0; i < C; i++) m_full[i] = 0;
    end else if (m_state == 1 || m_state == 2) begin
      matched = 0;
      for (int i = 0; i < C; i++)
        if (ch_we[i] && ch_addr[i*WA +: WA] == trig_addr) matched = 1;
      trg = (m_state == 1) && (trig_ext || (trig_en && matched));
      g = -1;
      for (int k = 0; k < C; k++) begin
        j = (m_rr + k) % C;
        if (g < 0 && m_full[j]) g = j;
      end
      if (g >= 0) begin
        hist.push_back(m_pend[g]);
        if (hist.size() > NB) void'(hist.pop_front());
        m_rr = (g + 1) % C;
        if (m_state == 2) begin
          m_left--;
          if (m_left == 0) m_state = 3;
        end
      end
      for (int i = 0; i < C; i++) begin
        if (ch_we[i]) begin
          if (!m_full[i] || i == g) begin
            m_full[i] = 1;
            m_pend[i] = {16'(m_ts), 4'(i), ch_addr[i*WA +: WA], ch_data[i*WD +: WD]};
          end else if (m_drop < 65535) begin
            m_drop++;
          end
        end else if (i == g) begin
          m_full[i] = 0;
        end
      end
      if (trg) begin
        m_left  = int'(post_count);
        m_state = (post_count == '0) ? 3 : 2;
      end
    end else begin
      for (int i = 0; i < C; i++) m_full[i] = 0;
    end
    m_ts++;
  endtask

  // Scoreboard for readout.
  logic [EW-1:0] exp_q [$];
  bit            rd_issue = 0;
  bit            issue_d = 0;

  always @(posedge clk) issue_d <= rd_issue;

  initial begin
    logic [EW-1:0] e;
    forever begin
      @(negedge clk);
      if (issue_d) begin
        if (exp_q.size() == 0) begin
          check("rd_unexpected", 64'(rd_valid), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("rd_data", 64'(rd_data), 64'(e));
          check("rd_valid_on_read", 64'(rd_valid), 64'd1);
        end
      end
    end
  end

  // Caller is at a negedge with inputs set; one clock edge passes.
  task automatic cycle();
    model_step();
    @(negedge clk);
    check("state", 64'(state), 64'(m_state));
    check("count", 64'(count), 64'(m_count()));
    check("dropped", 64'(dropped), 64'(m_drop));
    check("rd_valid", 64'(rd_valid), 64'(m_rdv));
    arm = 0; trig_ext = 0; ch_we = '0; rd_issue = 0;
  endtask

  task automatic do_reset();
    #2 reset_n = 1'b0;
    #1;
    check("rst_state", 64'(state), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_dropped", 64'(dropped), 64'd0);
    check("rst_rd_valid", 64'(rd_valid), 64'd0);
    check("rst_rd_data", 64'(rd_data), 64'd0);
    model_reset();
    arm = 0; trig_ext = 0; ch_we = '0; rd_issue = 0;
    #1 reset_n = 1'b1;
  endtask

  task automatic strobe(input int ch, input logic [WA-1:0] a, input logic [WD-1:0] d);
    ch_we[ch] = 1'b1;
    ch_addr[ch*WA +: WA] = a;
    ch_data[ch*WD +: WD] = d;
  endtask

  // Keeps traffic flowing so a POST window can close; bounded.
  task automatic wait_done(input int budget);
    int n = 0;
    while (m_state != 3 && n < budget) begin
      strobe($urandom_range(0, C-1), 10'h200, $urandom);
      cycle();
      n++;
    end
    check("done_reached", 64'(state), 64'd3);
  endtask

  task automatic read_all();
    int n = m_count();
    int base = hist.size() - n;
    for (int k = 0; k < n; k++) begin
      rd_addr  = DB'(k);
      rd_issue = 1;
      exp_q.push_back(hist[base + k]);
      cycle();
    end
    cycle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [EW-1:0] t1_exp;
    @(negedge clk);
    do_reset();
    repeat (3) cycle();

    // 1: single event then external trigger with empty post window
    arm = 1; cycle();
    while (m_ts != 20) cycle();
    strobe(0, 10'd5, 32'hA); cycle();
    while (m_ts != 30) cycle();
    trig_ext = 1; post_count = '0; cycle();
    check("t1_state", 64'(state), 64'd3);
    check("t1_count", 64'(count), 64'd1);
    rd_addr = '0; cycle();
    t1_exp = {16'd20, 4'd0, 10'd5, 32'hA};
    check("t1_entry", 64'(rd_data), 64'(t1_exp));
    check("t1_valid", 64'(rd_valid), 64'd1);
    read_all();

    // 2: all channels strobe together
    arm = 1; cycle();
    for (int i = 0; i < C; i++) strobe(i, 10'($urandom_range(64, 500)), $urandom);
    cycle();
    rd_addr = '0; cycle();
    check("t2_rd_idle", 64'(rd_data), 64'd0);
    repeat (5) cycle();
    check("t2_count", 64'(count), 64'd4);
    check("t2_dropped", 64'(dropped), 64'd0);
    trig_ext = 1; post_count = '0; cycle();
    read_all();

    // 3: contention on every channel for three cycles
    arm = 1; cycle();
    repeat (3) begin
      for (int i = 0; i < C; i++) strobe(i, 10'($urandom_range(64, 500)), $urandom);
      cycle();
    end
    repeat (8) cycle();
    check("t3_dropped_nz", 64'(dropped != 0), 64'd1);
    trig_ext = 1; post_count = '0; cycle();
    read_all();

    // 4: wrap with post-trigger window of 10
    arm = 1; cycle();
    for (int n = 0; n < 100; n++) begin
      strobe($urandom_range(0, C-1), 10'($urandom_range(64, 500)), 32'(n));
      cycle();
    end
    trig_ext = 1; post_count = 6'd10; cycle();
    for (int n = 0; n < 10; n++) begin
      strobe($urandom_range(0, C-1), 10'($urandom_range(64, 500)), 32'(100 + n));
      cycle();
    end
    wait_done(20);
    check("t4_count", 64'(count), 64'd64);
    rd_addr = '0; cycle();
    check("t4_oldest", 64'(rd_data[WD-1:0]), 64'd46);
    rd_addr = 6'd63; cycle();
    check("t4_newest", 64'(rd_data[WD-1:0]), 64'd109);
    read_all();

    // 5: address-match trigger, then arm beats a simultaneous trigger
    arm = 1; cycle();
    trig_en = 1; trig_addr = 10'h3F; post_count = 6'd3;
    strobe(2, 10'h3F, $urandom); cycle();
    check("t5_post", 64'(state), 64'd2);
    arm = 1; trig_ext = 1; cycle();
    check("t5_arm_wins", 64'(state), 64'd1);
    check("t5_count0", 64'(count), 64'd0);
    trig_en = 0;

    // 6: asynchronous reset in the middle of POST, then resume
    trig_ext = 1; post_count = 6'd20; cycle();
    repeat (5) begin strobe($urandom_range(0, C-1), 10'h100, $urandom); cycle(); end
    check("t6_in_post", 64'(state), 64'd2);
    do_reset();
    cycle();
    arm = 1; cycle();
    repeat (6) begin strobe($urandom_range(0, C-1), 10'h101, $urandom); cycle(); end
    trig_ext = 1; post_count = 6'd2; cycle();
    wait_done(20);
    read_all();

    // Randomized rounds
    for (int r = 0; r < 6; r++) begin
      trig_en = 1'($urandom_range(0, 1));
      trig_addr = 10'($urandom_range(0, 15));
      post_count = 6'($urandom_range(0, 40));
      arm = 1; cycle();
      for (int n = 0; n < 200 && m_state != 3; n++) begin
        for (int i = 0; i < C; i++)
          if ($urandom_range(0, 2) == 0) strobe(i, 10'($urandom_range(0, 15)), $urandom);
        if ($urandom_range(0, 99) == 0) trig_ext = 1;
        if ($urandom_range(0, 149) == 0) arm = 1;
        cycle();
      end
      if (m_state == 1) begin trig_ext = 1; cycle(); end
      wait_done(200);
      read_all();
    end

    repeat (2) cycle();
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
